usart_frame_parser: RTL

Sits directly downstream of the USART receiver and consumes its byte stream: an 8-bit data bus plus a toggle line that flips once per received byte. Assembles bytes into framed packets of the form SOF, LEN, payload, CHK. Checks length, checksum and inter-byte timeout, then holds one validated payload in an internal buffer until the consumer reads it out by address and releases it.

---
 rtl/usart_frame_parser.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/usart_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : usart_frame_parser
//  Description : Parses SOF/LEN/payload/CHK frames from a USART byte stream
//                and holds one validated payload for addressed read-out.
//  Revision    : 1.0 - initial release
// ============================================================================
module usart_frame_parser #(
    parameter int unsigned CLK_FREQ      = 100_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter logic [7:0]  SOF_BYTE      = 8'hA5,
    parameter int unsigned MAX_LEN       = 16,
    parameter int unsigned TIMEOUT_BYTES = 4,
    localparam int unsigned ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_toggle,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic [7:0]        frame_len,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout,
    output logic              err_overrun
);

    localparam int unsigned c_TIMEOUT_CLKS = TIMEOUT_BYTES * 10 * (CLK_FREQ / BAUD_RATE);
    localparam int unsigned c_TCNT_W       = $clog2(c_TIMEOUT_CLKS + 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(c_TIMEOUT_CLKS - 1);
    localparam int unsigned c_DEPTH        = 1 << ADDR_W;
    localparam logic [7:0]  c_MAX_LEN      = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN     = 3'd1,
        S_PAYLOAD = 3'd2,
        S_CHK     = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_toggle_q;
    logic [7:0]           r_len, w_len_nxt;
    logic [7:0]           r_chk, w_chk_nxt;
    logic [ADDR_W-1:0]    r_idx, w_idx_nxt;
    logic [c_TCNT_W-1:0]  r_tcnt, w_tcnt_nxt;
    logic [7:0]           r_frame_len, w_frame_len_nxt;
    logic                 r_frame_ready;
    logic [7:0]           r_rd_data;
    logic                 r_err_chk, r_err_len, r_err_timeout, r_err_overrun;
    logic                 w_err_chk, w_err_len, w_err_timeout, w_err_overrun;
    logic                 w_byte_stb;
    logic                 w_buf_we;
    logic                 w_counting;
    logic [7:0]           r_buf [c_DEPTH];

    assign w_byte_stb = rx_toggle ^ r_toggle_q;
    assign w_counting = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);

    always_comb begin
        w_state_nxt     = r_state;
        w_len_nxt       = r_len;
        w_chk_nxt       = r_chk;
        w_idx_nxt       = r_idx;
        w_frame_len_nxt = r_frame_len;
        w_tcnt_nxt      = '0;
        w_buf_we        = 1'b0;
        w_err_chk       = 1'b0;
        w_err_len       = 1'b0;
        w_err_timeout   = 1'b0;
        w_err_overrun   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_byte_stb && (rx_data == SOF_BYTE)) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_byte_stb) begin
                    if ((rx_data == 8'd0) || (rx_data > c_MAX_LEN)) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_len_nxt   = rx_data;
                        w_chk_nxt   = rx_data;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_byte_stb) begin
                    w_buf_we  = 1'b1;
                    w_chk_nxt = r_chk ^ rx_data;
                    w_idx_nxt = r_idx + ADDR_W'(1);
                    if (8'(r_idx) == (r_len - 8'd1)) begin
                        w_state_nxt = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (w_byte_stb) begin
                    if (rx_data == r_chk) begin
                        w_frame_len_nxt = r_len;
                        w_state_nxt     = S_HOLD;
                    end else begin
                        w_err_chk   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                // A byte landing with the ack is handled as if already in IDLE.
                if (frame_ack) begin
                    w_state_nxt = (w_byte_stb && (rx_data == SOF_BYTE)) ? S_LEN : S_IDLE;
                end else if (w_byte_stb) begin
                    w_err_overrun = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // A strobe in the expiry cycle wins: the byte is taken and the count restarts.
        if (w_counting && !w_byte_stb) begin
            if (r_tcnt == c_TCNT_LAST) begin
                w_err_timeout = 1'b1;
                w_state_nxt   = S_IDLE;
            end else begin
                w_tcnt_nxt = r_tcnt + c_TCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_toggle_q    <= rx_toggle;
            r_len         <= 8'd0;
            r_chk         <= 8'd0;
            r_idx         <= '0;
            r_tcnt        <= '0;
            r_frame_len   <= 8'd0;
            r_frame_ready <= 1'b0;
            r_rd_data     <= 8'd0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_toggle_q    <= rx_toggle;
            r_len         <= w_len_nxt;
            r_chk         <= w_chk_nxt;
            r_idx         <= w_idx_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_frame_len   <= w_frame_len_nxt;
            r_frame_ready <= (w_state_nxt == S_HOLD);
            r_rd_data     <= r_buf[rd_addr];
            r_err_chk     <= w_err_chk;
            r_err_len     <= w_err_len;
            r_err_timeout <= w_err_timeout;
            r_err_overrun <= w_err_overrun;
        end
    end

    // Payload storage is deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (reset && w_buf_we) begin
            r_buf[r_idx] <= rx_data;
        end
    end

    assign rd_data     = r_rd_data;
    assign frame_len   = r_frame_len;
    assign frame_ready = r_frame_ready;
    assign err_chk     = r_err_chk;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;
    assign err_overrun = r_err_overrun;

endmodule
`default_nettype wire
